// File: rtl/dma_channel_datapath.sv
// Register datapath of a DMA channel group: per-channel base/current address and word count,
// the shared temporary pair used by the active transfer, CPU byte access and terminal-count flags.
module dma_channel_datapath #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                programCondition,
  input  logic                loadAddr,
  input  logic                incrTemporaryAddressReg,
  input  logic                decrTemporaryWordCountReg,
  input  logic                updateCurrentAddressReg,
  input  logic                updateCurrentWordCountReg,
  input  logic                intEOP,
  input  logic [1:0]          activeChannel,
  input  logic [CHANNELS-1:0] autoInit,
  input  logic                cpuWr,
  input  logic                cpuRd,
  input  logic [3:0]          regSel,
  input  logic                clearFlipFlop,
  input  logic [DATA_W-1:0]   dataIn,
  output logic [DATA_W-1:0]   dataOut,
  output logic [ADDR_W-1:0]   addrOut,
  output logic                terminalCount,
  output logic [CHANNELS-1:0] tcStatus
);

  logic [ADDR_W-1:0] baseAddr  [CHANNELS];
  logic [ADDR_W-1:0] baseCount [CHANNELS];
  logic [ADDR_W-1:0] curAddr   [CHANNELS];
  logic [ADDR_W-1:0] curCount  [CHANNELS];
  logic [ADDR_W-1:0] tempAddr;
  logic [ADDR_W-1:0] tempCount;
  logic              bytePtr;

  logic              xferEn;
  logic              regAccess;
  logic              cpuWrite;
  logic              statusRd;
  logic              tcWrap;
  logic [1:0]        selCh;
  logic [ADDR_W-1:0] selReg;
  logic [CHANNELS-1:0] tcSet;

  function automatic logic [ADDR_W-1:0] putByte(input logic [ADDR_W-1:0] word,
                                                input logic hi,
                                                input logic [DATA_W-1:0] b);
    logic [ADDR_W-1:0] r;
    r = word;
    if (hi) r[ADDR_W-1:DATA_W] = b;
    else    r[DATA_W-1:0]      = b;
    return r;
  endfunction

  // CPU and transfer sides are mutually exclusive, selected by programCondition
  assign xferEn    = !programCondition;
  assign selCh     = regSel[2:1];
  assign regAccess = programCondition && (cpuWr || cpuRd) && !regSel[3];
  assign cpuWrite  = programCondition && cpuWr && !regSel[3];
  assign statusRd  = programCondition && cpuRd && (regSel == 4'h8);
  assign selReg    = regSel[0] ? curCount[selCh] : curAddr[selCh];
  assign addrOut   = tempAddr;

  // A decrement of an empty count (not overridden by a load) is the terminal count
  assign tcWrap = xferEn && decrTemporaryWordCountReg && !loadAddr && (tempCount == '0);

  always_comb begin
    tcSet = '0;
    if (xferEn && (intEOP || tcWrap)) tcSet[activeChannel] = 1'b1;
  end

  always_comb begin
    dataOut = '0;
    if (programCondition && cpuRd) begin
      if (!regSel[3])           dataOut = bytePtr ? selReg[ADDR_W-1:DATA_W] : selReg[DATA_W-1:0];
      else if (regSel == 4'h8)  dataOut = DATA_W'(tcStatus);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        baseAddr[i]  <= '0;
        baseCount[i] <= '0;
        curAddr[i]   <= '0;
        curCount[i]  <= '0;
      end
      tempAddr      <= '0;
      tempCount     <= '0;
      bytePtr       <= 1'b0;
      tcStatus      <= '0;
      terminalCount <= 1'b0;
    end else begin
      terminalCount <= tcWrap;
      // A flag set in the same cycle as a status read survives the clear
      tcStatus <= (statusRd ? '0 : tcStatus) | tcSet;

      if (clearFlipFlop)  bytePtr <= 1'b0;
      else if (regAccess) bytePtr <= ~bytePtr;

      if (cpuWrite) begin
        if (regSel[0]) begin
          baseCount[selCh] <= putByte(baseCount[selCh], bytePtr, dataIn);
          curCount[selCh]  <= putByte(curCount[selCh], bytePtr, dataIn);
        end else begin
          baseAddr[selCh] <= putByte(baseAddr[selCh], bytePtr, dataIn);
          curAddr[selCh]  <= putByte(curAddr[selCh], bytePtr, dataIn);
        end
      end

      if (xferEn) begin
        if (loadAddr) begin
          tempAddr  <= curAddr[activeChannel];
          tempCount <= curCount[activeChannel];
        end else begin
          if (incrTemporaryAddressReg)   tempAddr  <= tempAddr + ADDR_W'(1);
          if (decrTemporaryWordCountReg) tempCount <= tempCount - ADDR_W'(1);
        end
        // Autoinitialize restores the programmed base and wins over a write-back
        if (intEOP && autoInit[activeChannel]) begin
          curAddr[activeChannel]  <= baseAddr[activeChannel];
          curCount[activeChannel] <= baseCount[activeChannel];
        end else begin
          if (updateCurrentAddressReg)   curAddr[activeChannel]  <= tempAddr;
          if (updateCurrentWordCountReg) curCount[activeChannel] <= tempCount;
        end
      end
    end
  end

endmodule
